// File: rtl/kart_physics.sv
// Kart physics update engine. Each frame_tick starts a fixed six-state update:
// TURN works out the new heading and speed and addresses the sin/cos ROM.
// WAIT1 and WAIT2 cover the two-cycle ROM read. MOVE integrates the forward
// vector into an 11.9 fixed-point position. COMMIT clamps the position to the
// track, publishes all outputs together and pulses update_done.
module kart_physics #(
    parameter int START_X   = 1024,
    parameter int START_Y   = 1024,
    parameter int TURN_STEP = 3,
    parameter int ACCEL     = 1,
    parameter int MAX_SPEED = 32,
    parameter int FRICTION  = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_accel,
    input  logic        btn_brake,
    output logic [8:0]  direction,
    output logic [10:0] player_x,
    output logic [10:0] player_y,
    output logic [5:0]  speed,
    output logic        update_done
);

    typedef enum logic [2:0] {IDLE, TURN, WAIT1, WAIT2, MOVE, COMMIT} state_t;

    localparam logic [19:0]        START_X_FX = 20'(START_X * 512);
    localparam logic [19:0]        START_Y_FX = 20'(START_Y * 512);
    localparam logic [19:0]        EDGE_FX    = 20'(2047 * 512);
    localparam logic signed [21:0] POS_LIMIT  = 22'sd1048576;   // 2048.0
    localparam logic [8:0]         STEP       = 9'(TURN_STEP);
    localparam logic [7:0]         ACC        = 8'(ACCEL);
    localparam logic [7:0]         BRK        = 8'(2 * ACCEL);
    localparam logic [7:0]         FRIC       = 8'(FRICTION);
    localparam logic [7:0]         MAXS       = 8'(MAX_SPEED);

    // Bhaskara I sine approximation, scaled by 512. It is exact at 0, 90, 180
    // and 270 degrees, which keeps axis-aligned motion free of drift.
    function automatic logic signed [10:0] sin_deg(input int d);
        int a;
        int p;
        int mag;
        a   = (d >= 180) ? d - 180 : d;
        p   = a * (180 - a);
        mag = (2048 * p + (40500 - p) / 2) / (40500 - p);
        return (d >= 180) ? 11'(-mag) : 11'(mag);
    endfunction

    // ROM word layout: {sin, cos}, 11-bit signed each.
    logic [21:0] trig_rom [360];

    generate
        for (genvar gi = 0; gi < 360; gi++) begin : g_rom
            assign trig_rom[gi] = {sin_deg(gi), sin_deg((gi + 90) % 360)};
        end
    endgenerate

    state_t             state_reg;
    logic [8:0]         direction_reg;
    logic [5:0]         speed_reg;
    logic [19:0]        pos_x_reg;
    logic [19:0]        pos_y_reg;
    logic               update_done_reg;
    logic               left_reg, right_reg, accel_reg, brake_reg;
    logic [8:0]         rom_addr_reg;
    logic [5:0]         speed_work_reg;
    logic [21:0]        rom_data_reg;
    logic [21:0]        trig_reg;
    logic signed [21:0] sum_x_reg;
    logic signed [21:0] sum_y_reg;

    logic [8:0]         heading_next;
    logic [7:0]         speed_ext;
    logic [7:0]         speed_next;
    logic signed [17:0] prod_sin;
    logic signed [17:0] prod_cos;
    logic               clamp_x;
    logic               clamp_y;
    logic [19:0]        pos_x_next;
    logic [19:0]        pos_y_next;

    // New heading and speed from the buttons latched with frame_tick.
    always_comb begin
        heading_next = direction_reg;
        if (speed_reg != 6'd0 && (left_reg ^ right_reg)) begin
            if (right_reg) begin
                heading_next = direction_reg + STEP;
                if (heading_next >= 9'd360) begin
                    heading_next = heading_next - 9'd360;
                end
            end else if (direction_reg < STEP) begin
                heading_next = direction_reg + 9'd360 - STEP;
            end else begin
                heading_next = direction_reg - STEP;
            end
        end
        speed_ext = {2'b00, speed_reg};
        if (brake_reg) begin
            speed_next = (speed_ext < BRK) ? 8'd0 : speed_ext - BRK;
        end else if (accel_reg) begin
            speed_next = (speed_ext + ACC > MAXS) ? MAXS : speed_ext + ACC;
        end else begin
            speed_next = (speed_ext < FRIC) ? 8'd0 : speed_ext - FRIC;
        end
    end

    // Forward vector is (-sin, +cos); the products are in 1/512 pixel units.
    assign prod_sin = $signed({1'b0, speed_work_reg}) * $signed(trig_reg[21:11]);
    assign prod_cos = $signed({1'b0, speed_work_reg}) * $signed(trig_reg[10:0]);

    // Clamp both axes to [0.0, 2047.0]; any clamp means the kart hit a wall.
    always_comb begin
        clamp_x    = 1'b0;
        clamp_y    = 1'b0;
        pos_x_next = sum_x_reg[19:0];
        pos_y_next = sum_y_reg[19:0];
        if (sum_x_reg < 0) begin
            clamp_x    = 1'b1;
            pos_x_next = 20'd0;
        end else if (sum_x_reg >= POS_LIMIT) begin
            clamp_x    = 1'b1;
            pos_x_next = EDGE_FX;
        end
        if (sum_y_reg < 0) begin
            clamp_y    = 1'b1;
            pos_y_next = 20'd0;
        end else if (sum_y_reg >= POS_LIMIT) begin
            clamp_y    = 1'b1;
            pos_y_next = EDGE_FX;
        end
    end

    // Two-stage ROM read: the address is registered in TURN and the word is
    // usable in MOVE.
    always_ff @(posedge clk_in) begin
        rom_data_reg <= trig_rom[rom_addr_reg];
        trig_reg     <= rom_data_reg;
    end

    // Update sequencer together with all committed state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg       <= IDLE;
            direction_reg   <= 9'd0;
            speed_reg       <= 6'd0;
            pos_x_reg       <= START_X_FX;
            pos_y_reg       <= START_Y_FX;
            update_done_reg <= 1'b0;
            left_reg        <= 1'b0;
            right_reg       <= 1'b0;
            accel_reg       <= 1'b0;
            brake_reg       <= 1'b0;
            rom_addr_reg    <= 9'd0;
            speed_work_reg  <= 6'd0;
            sum_x_reg       <= 22'sd0;
            sum_y_reg       <= 22'sd0;
        end else begin
            update_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (frame_tick) begin
                        left_reg  <= btn_left;
                        right_reg <= btn_right;
                        accel_reg <= btn_accel;
                        brake_reg <= btn_brake;
                        state_reg <= TURN;
                    end
                end
                TURN: begin
                    rom_addr_reg   <= heading_next;
                    speed_work_reg <= speed_next[5:0];
                    state_reg      <= WAIT1;
                end
                WAIT1: state_reg <= WAIT2;
                WAIT2: state_reg <= MOVE;
                MOVE: begin
                    sum_x_reg <= $signed({2'b00, pos_x_reg}) - $signed({{4{prod_sin[17]}}, prod_sin});
                    sum_y_reg <= $signed({2'b00, pos_y_reg}) + $signed({{4{prod_cos[17]}}, prod_cos});
                    state_reg <= COMMIT;
                end
                COMMIT: begin
                    direction_reg   <= rom_addr_reg;
                    pos_x_reg       <= pos_x_next;
                    pos_y_reg       <= pos_y_next;
                    speed_reg       <= (clamp_x || clamp_y) ? 6'd0 : speed_work_reg;
                    update_done_reg <= 1'b1;
                    state_reg       <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign direction   = direction_reg;
    assign player_x    = pos_x_reg[19:9];
    assign player_y    = pos_y_reg[19:9];
    assign speed       = speed_reg;
    assign update_done = update_done_reg;

endmodule

// File: tb/tb_kart_physics.sv
// Directed bench for kart_physics: drives button frames and checks committed
// outputs against hand-worked values.
module tb_kart_physics;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        frame_tick = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_accel = 1'b0;
    logic        btn_brake = 1'b0;
    logic [8:0]  direction;
    logic [10:0] player_x;
    logic [10:0] player_y;
    logic [5:0]  speed;
    logic        update_done;

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;

    kart_physics dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .frame_tick  (frame_tick),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_accel   (btn_accel),
        .btn_brake   (btn_brake),
        .direction   (direction),
        .player_x    (player_x),
        .player_y    (player_y),
        .speed       (speed),
        .update_done (update_done)
    );

    always #5 clk_in = ~clk_in;

    // Counts update_done pulses, sampled away from the active edge.
    always @(negedge clk_in) begin
        if (update_done === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    // One frame: pulse frame_tick with buttons, wait for update_done, check
    // the 5-edge latency and the single-cycle pulse width.
    task automatic frame(input string tag, input logic l, input logic r, input logic a, input logic b);
        int c;
        @(negedge clk_in);
        frame_tick = 1'b1;
        btn_left = l; btn_right = r; btn_accel = a; btn_brake = b;
        @(negedge clk_in);
        frame_tick = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_accel = 1'b0; btn_brake = 1'b0;
        c = 0;
        while (update_done !== 1'b1 && c < 20) begin
            @(negedge clk_in);
            c++;
        end
        check({tag, "_latency"}, c, 5);
        @(negedge clk_in);
        check({tag, "_pulse_width"}, update_done, 0);
        $display("frame %s: dir=%0d x=%0d y=%0d speed=%0d", tag, direction, player_x, player_y, speed);
    endtask

    initial begin
        int base_x;
        int base_y;
        int base_p;

        // Reset values
        do_reset();
        @(negedge clk_in);
        check("rst_direction", direction, 0);
        check("rst_x", player_x, 1024);
        check("rst_y", player_y, 1024);
        check("rst_speed", speed, 0);
        check("rst_done", update_done, 0);

        // Turning at speed 0 does nothing
        frame("right_at_rest", 1'b0, 1'b1, 1'b0, 1'b0);
        check("rest_dir", direction, 0);
        check("rest_speed", speed, 0);
        check("rest_y", player_y, 1024);

        // First accelerating frame
        base_p = pulse_cnt;
        frame("accel1", 1'b0, 1'b0, 1'b1, 1'b0);
        check("accel1_speed", speed, 1);
        check("accel1_dir", direction, 0);
        check("accel1_y", player_y, 1025);
        check("accel1_x", player_x, 1024);
        check("accel1_pulses", pulse_cnt - base_p, 1);

        // Up to speed 5 heading up: y = 1025 + 2+3+4+5
        for (int i = 0; i < 4; i++) frame("accel", 1'b0, 1'b0, 1'b1, 1'b0);
        check("spd5_speed", speed, 5);
        check("spd5_y", player_y, 1039);

        // Wrap below zero, then back over 359
        frame("left_wrap", 1'b1, 1'b0, 1'b0, 1'b0);
        check("left_wrap_dir", direction, 357);
        check("left_wrap_speed", speed, 4);
        frame("right_wrap", 1'b0, 1'b1, 1'b0, 1'b0);
        check("right_wrap_dir", direction, 0);
        check("right_wrap_speed", speed, 3);
        frame("both_turn", 1'b1, 1'b1, 1'b1, 1'b0);
        check("both_dir", direction, 0);
        check("both_speed", speed, 4);

        // Brake wins over accel; a tick 2 cycles later is ignored
        base_p = pulse_cnt;
        @(negedge clk_in);
        frame_tick = 1'b1; btn_accel = 1'b1; btn_brake = 1'b1;
        @(negedge clk_in);
        frame_tick = 1'b0; btn_accel = 1'b0; btn_brake = 1'b0;
        @(negedge clk_in);
        frame_tick = 1'b1; btn_accel = 1'b1;
        @(negedge clk_in);
        frame_tick = 1'b0; btn_accel = 1'b0;
        repeat (15) @(negedge clk_in);
        check("brake_speed", speed, 2);
        check("ignored_tick_pulses", pulse_cnt - base_p, 1);
        $display("brake frame: speed=%0d pulses=%0d", speed, pulse_cnt - base_p);

        // Reach heading 90 at speed 10, then coast once
        do_reset();
        frame("d_a1", 1'b0, 1'b0, 1'b1, 1'b0);
        frame("d_a2", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) frame("d_ra", 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) begin
            frame("d_ra", 1'b0, 1'b1, 1'b1, 1'b0);
            frame("d_r", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("d90_dir", direction, 90);
        check("d90_speed", speed, 10);
        base_x = int'(player_x);
        base_y = int'(player_y);
        frame("coast90", 1'b0, 1'b0, 1'b0, 1'b0);
        check("coast90_speed", speed, 9);
        check("coast90_x", player_x, 32'(base_x - 9));
        check("coast90_y", player_y, 32'(base_y));

        // Drive into the top wall: 32 accel frames reach y=1552, speed 32;
        // 15 more at full speed reach y=2032
        do_reset();
        for (int i = 0; i < 47; i++) frame("e_accel", 1'b0, 1'b0, 1'b1, 1'b0);
        check("e_pre_y", player_y, 2032);
        check("e_pre_speed", speed, 32);
        frame("e_wall", 1'b0, 1'b0, 1'b1, 1'b0);
        check("wall_y", player_y, 2047);
        check("wall_speed", speed, 0);
        check("wall_x", player_x, 1024);
        frame("e_edge", 1'b0, 1'b0, 1'b1, 1'b0);
        check("edge_y", player_y, 2047);
        check("edge_speed", speed, 0);

        // Reset in WAIT2 aborts the update
        base_p = pulse_cnt;
        @(negedge clk_in);
        frame_tick = 1'b1; btn_accel = 1'b1;
        @(negedge clk_in);
        frame_tick = 1'b0; btn_accel = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (10) @(negedge clk_in);
        check("abort_pulses", pulse_cnt - base_p, 0);
        check("abort_y", player_y, 1024);
        check("abort_x", player_x, 1024);
        check("abort_speed", speed, 0);
        check("abort_dir", direction, 0);
        $display("abort: pulses=%0d y=%0d", pulse_cnt - base_p, player_y);

        // A tick coincident with reset is ignored
        base_p = pulse_cnt;
        @(negedge clk_in);
        rst_in = 1'b1; frame_tick = 1'b1; btn_accel = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0; frame_tick = 1'b0; btn_accel = 1'b0;
        repeat (10) @(negedge clk_in);
        check("rst_tick_pulses", pulse_cnt - base_p, 0);
        check("rst_tick_speed", speed, 0);
        $display("reset tick: pulses=%0d speed=%0d", pulse_cnt - base_p, speed);

        // Normal operation afterwards
        frame("post_rst", 1'b0, 1'b0, 1'b1, 1'b0);
        check("post_rst_speed", speed, 1);
        check("post_rst_y", player_y, 1025);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kart_physics.md
KART_PHYSICS -- requirements
Module: kart_physics

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- START_X, 1024: reset integer x position.
- START_Y, 1024: reset integer y position.
- TURN_STEP, 3: degrees turned per frame.
- ACCEL, 1: speed gain per frame while accelerating.
- MAX_SPEED, 32: speed ceiling, at most 63.
- FRICTION, 1: speed loss per frame when coasting.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_in, in, 1: single system clock.
- rst_in, in, 1: synchronous, active-high reset.
- frame_tick, in, 1: one-cycle pulse that starts one physics update.
- btn_left, in, 1: turn counter-clockwise.
- btn_right, in, 1: turn clockwise.
- btn_accel, in, 1: accelerate.
- btn_brake, in, 1: brake.
- direction, out, 9: heading in degrees, 0..359; 0 means screen-up.
- player_x, out, 11: integer x position on the track.
- player_y, out, 11: integer y position on the track.
- speed, out, 6: current speed in pixels/frame, unsigned.
- update_done, out, 1: one-cycle pulse when the outputs take new values.

REQ-003 The block SHALL use one clock (clk_in). Reset (rst_in) SHALL be synchronous and active-high.

Function
REQ-004 The FSM states SHALL be IDLE, TURN, WAIT1, WAIT2, MOVE, COMMIT. Transitions:
- IDLE goes to TURN on frame_tick.
- Every other state advances unconditionally, one per cycle; COMMIT returns to IDLE.

REQ-005 frame_tick SHALL be ignored in every state other than IDLE. Ignored ticks are not queued.

REQ-006 Button inputs SHALL be sampled once, on the edge that samples frame_tick. They are held internally for the rest of that update.

REQ-007 Heading in TURN:
- Turning applies only if speed before the update is nonzero.
- Right alone adds TURN_STEP, modulo 360.
- Left alone subtracts TURN_STEP, modulo 360.
- Both or neither: no change.
- Wrap examples: 358+3 gives 1; 1-3 gives 358.

REQ-008 Speed in TURN:
- Brake (wins over accel): speed = max(speed - 2*ACCEL, 0).
- Else accel: speed = min(speed + ACCEL, MAX_SPEED).
- Else: speed = max(speed - FRICTION, 0).

REQ-009 An internal sin/cos ROM SHALL provide values for the new heading.
- Depth 360, 11-bit signed, scale 512: cos(0)=512, sin(0)=0, sin(90)=512, cos(180)=-512.
- Address is registered in TURN; data is valid in MOVE (2-cycle read latency).

REQ-010 Position SHALL be held internally as 11 integer bits plus 9 fraction bits, unsigned.

REQ-011 The forward vector SHALL be (-sin, +cos). In MOVE, using the new speed:
- dx = -(speed*sin), in 1/512-pixel units.
- dy = +(speed*cos), in 1/512-pixel units.
- Products SHALL be at least 18-bit signed. Sums SHALL be at least 22-bit signed, with no intermediate overflow.

REQ-012 In COMMIT, each axis SHALL be clamped to [0.0, 2047.0].
- A result below 0 becomes 0 with fraction 0.
- A result at or above 2048 becomes 2047 with fraction 0.
- Any clamp on either axis forces the committed speed to 0 (wall hit).

REQ-013 In COMMIT:
- direction, player_x, player_y and speed SHALL all update together.
- player_x and player_y are the integer parts of the committed position.
- update_done is high for exactly that one cycle.
- Between commits, all outputs SHALL hold stable.

REQ-014 Latency SHALL be fixed: outputs change, and update_done rises, on the 5th rising edge after the edge that sampled frame_tick.

Reset
REQ-015 While rst_in is high at a clock edge, the block SHALL load:
- state IDLE;
- direction 0;
- player_x START_X and player_y START_Y, with fractions 0;
- speed 0;
- update_done 0;
- latched buttons cleared.

REQ-016 Reset asserted mid-update SHALL abort the update with no commit. A frame_tick coincident with reset SHALL be ignored.

Verification
REQ-017 Reset, then a tick with btn_accel -> 5 edges later: speed 1, direction 0, player_y 1025, player_x 1024, single update_done pulse.

REQ-018 Speed 0, tick with btn_right -> direction stays 0. Speed 5, direction 358, tick with btn_right -> direction 1.

REQ-019 Speed 10, direction 90, tick with no buttons -> speed 9, player_x decreases by 9, player_y unchanged.

REQ-020 player_y 2040, direction 0, speed 20, tick with btn_accel -> player_y 2047, speed 0.

REQ-021 Tick with btn_accel and btn_brake from speed 4 -> speed 2. A second tick 2 cycles later -> ignored, only one update_done.

REQ-022 rst_in pulsed in WAIT2 -> no update_done, outputs equal reset values, next tick processes normally.
